// File: rtl/audio_clk_gen.sv
// ============================================================================
// Module      : audio_clk_gen
// Description : Audio serial-interface clock generator. Derives MCLK, BCLK and
//               LRCK plus one-cycle shift/load strobes from the system clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_clk_gen (
    input  logic CLK,
    input  logic RESET,
    output logic MCLK,
    output logic BCLK,
    output logic LRCK,
    output logic OUT_SHIFT,
    output logic IN_SHIFT,
    output logic LOAD
);

    localparam logic [5:0] c_PHASE_MAX = 6'd63;
    localparam logic [5:0] c_BIT_MAX   = 6'd47;
    localparam logic [5:0] c_BIT_RIGHT = 6'd24;
    localparam logic [5:0] c_PHASE_MID = 6'd32;

    logic [5:0] r_phase;
    logic [5:0] r_bit;
    logic [5:0] w_phase_next;
    logic [5:0] w_bit_next;

    // Next counter state; the outputs are registered from this so that every
    // pin comes straight off a flop and already reflects the new phase.
    always_comb begin
        w_phase_next = r_phase + 6'd1;
        w_bit_next   = r_bit;
        if (r_phase == c_PHASE_MAX) begin
            if (r_bit == c_BIT_MAX) begin
                w_bit_next = 6'd0;
            end else begin
                w_bit_next = r_bit + 6'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_phase   <= 6'd0;
            r_bit     <= 6'd0;
            MCLK      <= 1'b0;
            BCLK      <= 1'b0;
            LRCK      <= 1'b0;
            OUT_SHIFT <= 1'b0;
            IN_SHIFT  <= 1'b0;
            LOAD      <= 1'b0;
        end else begin
            r_phase   <= w_phase_next;
            r_bit     <= w_bit_next;
            MCLK      <= w_phase_next[2];
            BCLK      <= w_phase_next[5];
            LRCK      <= (w_bit_next >= c_BIT_RIGHT);
            OUT_SHIFT <= (w_phase_next == 6'd0);
            IN_SHIFT  <= (w_phase_next == c_PHASE_MID);
            LOAD      <= (w_phase_next == c_PHASE_MAX) && (w_bit_next == c_BIT_MAX);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_audio_clk_gen.sv
// ============================================================================
// Module      : tb_audio_clk_gen
// Description : Self-checking bench for audio_clk_gen (scoreboard + vectors).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_clk_gen;

    logic CLK;
    logic RESET;
    logic MCLK, BCLK, LRCK, OUT_SHIFT, IN_SHIFT, LOAD;

    audio_clk_gen dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MCLK      (MCLK),
        .BCLK      (BCLK),
        .LRCK      (LRCK),
        .OUT_SHIFT (OUT_SHIFT),
        .IN_SHIFT  (IN_SHIFT),
        .LOAD      (LOAD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Output vector order: {MCLK, BCLK, LRCK, OUT_SHIFT, IN_SHIFT, LOAD}
    typedef struct {
        int         edge_n;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        logic       rst;
        int         edge_n;
        logic [5:0] v;
    } sb_t;

    localparam int NV = 14;
    vec_t tv [NV];
    sb_t  sb [$];

    int         checks = 0;
    int         errors = 0;
    int         e_m    = 0;
    logic [5:0] prev   = 6'd0;
    bit         stats_en = 1'b0;
    int         n_mclk_rise = 0, n_bclk_rise = 0, n_out = 0, n_in = 0, n_load = 0, n_lrck_hi = 0;

    function automatic logic [5:0] model(input int e);
        logic [5:0] p, b;
        p = 6'(e % 64);
        b = 6'((e / 64) % 48);
        return {p[2], p[5], (b >= 6'd24), (p == 6'd0), (p == 6'd32), (p == 6'd63 && b == 6'd47)};
    endfunction

    task automatic check(input string name, input int e, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s edge %0d got %b want %b", name, e, got, want);
        end
    endtask

    task automatic step(input logic rst);
        sb_t        x;
        logic [5:0] outs;
        RESET = rst;
        if (rst) begin
            e_m = 0;
            x.v = 6'd0;
        end else begin
            e_m++;
            x.v = model(e_m);
        end
        x.rst    = rst;
        x.edge_n = e_m;
        sb.push_back(x);
        @(posedge CLK);
        @(negedge CLK);
        x    = sb.pop_front();
        outs = {MCLK, BCLK, LRCK, OUT_SHIFT, IN_SHIFT, LOAD};
        check("model", x.edge_n, outs, x.v);
        if (!x.rst) begin
            check("out_shift_align", x.edge_n, {5'd0, OUT_SHIFT}, {5'd0, prev[4] & ~BCLK});
            check("in_shift_align", x.edge_n, {5'd0, IN_SHIFT}, {5'd0, ~prev[4] & BCLK});
            if (LRCK !== prev[3])
                check("lrck_on_out_shift", x.edge_n, {5'd0, OUT_SHIFT}, 6'd1);
            if ((prev[2] | prev[1] | prev[0]) && (outs[2:0] & prev[2:0]) != 3'b000)
                check("strobe_width", x.edge_n, {3'd0, outs[2:0] & prev[2:0]}, 6'd0);
            for (int k = 0; k < NV; k++)
                if (tv[k].edge_n == x.edge_n)
                    check("vector", x.edge_n, outs, tv[k].exp);
            if (stats_en && x.edge_n >= 3073 && x.edge_n <= 6144) begin
                if (MCLK && !prev[5]) n_mclk_rise++;
                if (BCLK && !prev[4]) n_bclk_rise++;
                if (LRCK) n_lrck_hi++;
                if (OUT_SHIFT) n_out++;
                if (IN_SHIFT) n_in++;
                if (LOAD) n_load++;
            end
        end
        prev = outs;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1,    6'b000000};
        tv[1]  = '{3,    6'b000000};
        tv[2]  = '{4,    6'b100000};
        tv[3]  = '{8,    6'b000000};
        tv[4]  = '{31,   6'b100000};
        tv[5]  = '{32,   6'b010010};
        tv[6]  = '{63,   6'b110000};
        tv[7]  = '{64,   6'b000100};
        tv[8]  = '{1535, 6'b110000};
        tv[9]  = '{1536, 6'b001100};
        tv[10] = '{3071, 6'b111001};
        tv[11] = '{3072, 6'b000100};
        tv[12] = '{6143, 6'b111001};
        tv[13] = '{6144, 6'b000100};

        RESET = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 20; i++) step(1'b1);

        // Two full frames, with per-frame statistics gathered over the second.
        stats_en = 1'b1;
        run(6144);
        stats_en = 1'b0;
        check("mclk_rises_per_frame", 0, 6'(n_mclk_rise / 8), 6'd48);
        check("mclk_rises_mod", 0, 6'(n_mclk_rise % 8), 6'd0);
        check("bclk_rises_per_frame", 0, 6'(n_bclk_rise), 6'd48);
        check("out_shift_per_frame", 0, 6'(n_out), 6'd48);
        check("in_shift_per_frame", 0, 6'(n_in), 6'd48);
        check("load_per_frame", 0, 6'(n_load), 6'd1);
        check("lrck_high_cycles", 0, 6'(n_lrck_hi / 64), 6'd24);
        check("lrck_high_mod", 0, 6'(n_lrck_hi % 64), 6'd0);

        // One-cycle reset landing on edge 2000 (LRCK and MCLK high), then replay.
        step(1'b1);
        run(1999);
        step(1'b1);
        run(3072);

        // Reset while BCLK and LRCK are both high (edge 1650), then a long hold.
        step(1'b1);
        run(1650);
        for (int i = 0; i < 10; i++) step(1'b1);
        run(100);

        check("scoreboard_empty", 0, 6'(sb.size()), 6'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
